// File: rtl/mpu_load_store_unit_pkg.sv
// Shared types and defaults for the MPU matrix load/store engine.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mpu_load_store_unit_pkg;

    localparam int MPU_FP_WIDTH  = 64;
    localparam int MPU_MAX_ROWS  = 4;
    localparam int MPU_MAX_COLS  = 4;
    localparam int MPU_NUM_SLOTS = 2;

    typedef logic [MPU_FP_WIDTH-1:0] fp_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE
    } mpu_ls_state_e;

    // Index width that never collapses to zero bits for a size-1 dimension.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mpu_load_store_unit_if.sv
// Host-side load stream, store stream and status bundle of the load/store engine.
// Latency: n/a (wiring only); slave = engine side, master = host/test side.
// Backpressure: load via load_ready_o, store via store_ready_i.
interface mpu_load_store_unit_if
    import mpu_load_store_unit_pkg::*;
#(
    parameter int FP_WIDTH  = MPU_FP_WIDTH,
    parameter int MAX_ROWS  = MPU_MAX_ROWS,
    parameter int MAX_COLS  = MPU_MAX_COLS,
    parameter int NUM_SLOTS = MPU_NUM_SLOTS
) ();
    localparam int SW  = idx_w(NUM_SLOTS);
    localparam int RDW = $clog2(MAX_ROWS + 1);
    localparam int CDW = $clog2(MAX_COLS + 1);

    logic                 load_req_i;
    logic [SW-1:0]        load_slot_i;
    logic [RDW-1:0]       load_rows_i;
    logic [CDW-1:0]       load_cols_i;
    logic [FP_WIDTH-1:0]  load_data_i;
    logic                 load_valid_i;
    logic                 load_ready_o;
    logic                 load_done_o;
    logic                 store_req_i;
    logic [SW-1:0]        store_slot_i;
    logic                 store_transpose_i;
    logic [FP_WIDTH-1:0]  store_data_o;
    logic                 store_valid_o;
    logic                 store_ready_i;
    logic                 store_last_o;
    logic                 store_done_o;
    logic [NUM_SLOTS-1:0] slot_valid_o;
    logic                 busy_o;
    logic                 error_o;

    modport slave (
        input  load_req_i, load_slot_i, load_rows_i, load_cols_i, load_data_i, load_valid_i,
        input  store_req_i, store_slot_i, store_transpose_i, store_ready_i,
        output load_ready_o, load_done_o, store_data_o, store_valid_o, store_last_o,
        output store_done_o, slot_valid_o, busy_o, error_o
    );

    modport master (
        output load_req_i, load_slot_i, load_rows_i, load_cols_i, load_data_i, load_valid_i,
        output store_req_i, store_slot_i, store_transpose_i, store_ready_i,
        input  load_ready_o, load_done_o, store_data_o, store_valid_o, store_last_o,
        input  store_done_o, slot_valid_o, busy_o, error_o
    );
endinterface

// File: rtl/mpu_matrix_index_ctr.sv
// Row/col element counter over a runtime rows x cols matrix; inner index is col, or row when transposed.
// Latency: advances one element on the edge where inc is high; last is combinational on the current index.
// Backpressure: holds its value whenever inc is low.
module mpu_matrix_index_ctr
    import mpu_load_store_unit_pkg::*;
#(
    parameter int MAX_ROWS = MPU_MAX_ROWS,
    parameter int MAX_COLS = MPU_MAX_COLS,
    localparam int RW  = idx_w(MAX_ROWS),
    localparam int CW  = idx_w(MAX_COLS),
    localparam int RDW = $clog2(MAX_ROWS + 1),
    localparam int CDW = $clog2(MAX_COLS + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           inc,
    input  logic           transpose,
    input  logic [RDW-1:0] rows,
    input  logic [CDW-1:0] cols,
    output logic [RW-1:0]  row,
    output logic [CW-1:0]  col,
    output logic           last
);
    logic row_end;
    logic col_end;

    assign row_end = (RDW'(row) == rows - RDW'(1));
    assign col_end = (CDW'(col) == cols - CDW'(1));
    assign last    = row_end && col_end;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (transpose) begin
                row <= row_end ? '0 : row + RW'(1);
                if (row_end) col <= col_end ? '0 : col + CW'(1);
            end else begin
                col <= col_end ? '0 : col + CW'(1);
                if (col_end) row <= row_end ? '0 : row + RW'(1);
            end
        end
    end
endmodule

// File: rtl/mpu_load_store_unit.sv
// Matrix load/store engine: fills one of NUM_SLOTS register slots row-major, streams a slot back (optionally transposed).
// Latency: request accepted at edge t -> ready/valid from t+1; one element per cycle; done pulses the cycle after the last beat.
// Backpressure: store output holds data/valid/last while store_ready_i is low; load stalls on load_valid_i low.
module mpu_load_store_unit
    import mpu_load_store_unit_pkg::*;
#(
    parameter int FP_WIDTH  = MPU_FP_WIDTH,
    parameter int MAX_ROWS  = MPU_MAX_ROWS,
    parameter int MAX_COLS  = MPU_MAX_COLS,
    parameter int NUM_SLOTS = MPU_NUM_SLOTS
) (
    input logic                  clk,
    input logic                  rst,
    mpu_load_store_unit_if.slave bus
);
    localparam int SW  = idx_w(NUM_SLOTS);
    localparam int RW  = idx_w(MAX_ROWS);
    localparam int CW  = idx_w(MAX_COLS);
    localparam int RDW = $clog2(MAX_ROWS + 1);
    localparam int CDW = $clog2(MAX_COLS + 1);

    mpu_ls_state_e        state_q, state_d;
    logic [SW-1:0]        slot_q;
    logic                 transpose_q;
    logic [RDW-1:0]       cur_rows_q;
    logic [CDW-1:0]       cur_cols_q;
    logic [NUM_SLOTS-1:0] slot_valid_q;
    logic                 load_done_q, store_done_q, error_q;

    logic [FP_WIDTH-1:0]  mem      [NUM_SLOTS][MAX_ROWS][MAX_COLS];
    logic [RDW-1:0]       rows_mem [NUM_SLOTS];
    logic [CDW-1:0]       cols_mem [NUM_SLOTS];

    logic          load_ok, store_ok, load_acc, store_acc, req_err;
    logic          ctr_clr, ctr_inc, ctr_last, fin_load, fin_store;
    logic [RW-1:0] ctr_row;
    logic [CW-1:0] ctr_col;

    assign load_ok = (bus.load_rows_i != '0) && (int'(bus.load_rows_i) <= MAX_ROWS) &&
                     (bus.load_cols_i != '0) && (int'(bus.load_cols_i) <= MAX_COLS) &&
                     (int'(bus.load_slot_i) < NUM_SLOTS);
    assign store_ok = (int'(bus.store_slot_i) < NUM_SLOTS) && slot_valid_q[bus.store_slot_i];

    assign fin_load  = (state_q == LOAD)  && bus.load_valid_i  && ctr_last;
    assign fin_store = (state_q == STORE) && bus.store_ready_i && ctr_last;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Load has priority; a simultaneous store request is silently dropped.
    always_comb begin
        state_d   = state_q;
        load_acc  = 1'b0;
        store_acc = 1'b0;
        req_err   = 1'b0;
        ctr_clr   = 1'b0;
        ctr_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_req_i) begin
                    if (load_ok) begin
                        load_acc = 1'b1;
                        ctr_clr  = 1'b1;
                        state_d  = LOAD;
                    end else begin
                        req_err = 1'b1;
                    end
                end else if (bus.store_req_i) begin
                    if (store_ok) begin
                        store_acc = 1'b1;
                        ctr_clr   = 1'b1;
                        state_d   = STORE;
                    end else begin
                        req_err = 1'b1;
                    end
                end
            end
            LOAD: begin
                ctr_inc = bus.load_valid_i;
                if (fin_load) state_d = IDLE;
            end
            STORE: begin
                ctr_inc = bus.store_ready_i;
                if (fin_store) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    mpu_matrix_index_ctr #(
        .MAX_ROWS (MAX_ROWS),
        .MAX_COLS (MAX_COLS)
    ) u_idx (
        .clk       (clk),
        .rst       (rst),
        .clr       (ctr_clr),
        .inc       (ctr_inc),
        .transpose (transpose_q && (state_q == STORE)),
        .rows      (cur_rows_q),
        .cols      (cur_cols_q),
        .row       (ctr_row),
        .col       (ctr_col),
        .last      (ctr_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            transpose_q  <= 1'b0;
            cur_rows_q   <= '0;
            cur_cols_q   <= '0;
            slot_valid_q <= '0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            load_done_q  <= fin_load;
            store_done_q <= fin_store;
            error_q      <= req_err;
            if (load_acc) begin
                slot_q                        <= bus.load_slot_i;
                transpose_q                   <= 1'b0;
                cur_rows_q                    <= bus.load_rows_i;
                cur_cols_q                    <= bus.load_cols_i;
                slot_valid_q[bus.load_slot_i] <= 1'b0;
            end
            if (store_acc) begin
                slot_q      <= bus.store_slot_i;
                transpose_q <= bus.store_transpose_i;
                cur_rows_q  <= rows_mem[bus.store_slot_i];
                cur_cols_q  <= cols_mem[bus.store_slot_i];
            end
            if (fin_load) slot_valid_q[slot_q] <= 1'b1;
        end
    end

    // Storage is not reset; contents only matter once slot_valid marks them.
    always_ff @(posedge clk) begin
        if (load_acc) begin
            rows_mem[bus.load_slot_i] <= bus.load_rows_i;
            cols_mem[bus.load_slot_i] <= bus.load_cols_i;
        end
        if ((state_q == LOAD) && bus.load_valid_i) begin
            mem[slot_q][ctr_row][ctr_col] <= bus.load_data_i;
        end
    end

    assign bus.load_ready_o  = (state_q == LOAD);
    assign bus.load_done_o   = load_done_q;
    assign bus.store_valid_o = (state_q == STORE);
    assign bus.store_last_o  = (state_q == STORE) && ctr_last;
    assign bus.store_data_o  = (state_q == STORE) ? mem[slot_q][ctr_row][ctr_col] : '0;
    assign bus.store_done_o  = store_done_q;
    assign bus.slot_valid_o  = slot_valid_q;
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.error_o       = error_q;
endmodule

// File: tb/tb_mpu_load_store_unit.sv
module tb_mpu_load_store_unit;
    import mpu_load_store_unit_pkg::*;

    localparam int FPW = 64;
    localparam int MR  = 4;
    localparam int MC  = 4;
    localparam int NS  = 2;
    localparam int SW  = 1;
    localparam int RDW = 3;
    localparam int CDW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mpu_load_store_unit_if #(.FP_WIDTH(FPW), .MAX_ROWS(MR), .MAX_COLS(MC), .NUM_SLOTS(NS)) bus ();

    mpu_load_store_unit #(.FP_WIDTH(FPW), .MAX_ROWS(MR), .MAX_COLS(MC), .NUM_SLOTS(NS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int        checks = 0;
    int        errors = 0;
    fp_t       exp_q[$];
    fp_t       model [NS][MR][MC];
    int        m_rows[NS];
    int        m_cols[NS];
    logic [NS-1:0] sv_model = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_mx(input int slot, input int rows, input int cols, input int base, input bit with_store);
        @(negedge clk);
        bus.load_req_i   = 1'b1;
        bus.load_slot_i  = SW'(slot);
        bus.load_rows_i  = RDW'(rows);
        bus.load_cols_i  = CDW'(cols);
        bus.store_req_i  = with_store;
        bus.store_slot_i = '0;
        @(negedge clk);
        bus.load_req_i  = 1'b0;
        bus.store_req_i = 1'b0;
        sv_model[slot]  = 1'b0;
        m_rows[slot]    = rows;
        m_cols[slot]    = cols;
        chk("ld_slot_cleared", 64'(bus.slot_valid_o), 64'(sv_model));
        for (int k = 0; k < rows * cols; k++) begin
            bus.load_valid_i = 1'b1;
            bus.load_data_i  = $realtobits(real'(base + k));
            model[slot][k / cols][k % cols] = bus.load_data_i;
            chk("ld_ready", 64'(bus.load_ready_o), 64'd1);
            if (with_store) chk("ld_no_store_beat", 64'(bus.store_valid_o), 64'd0);
            @(negedge clk);
        end
        bus.load_valid_i = 1'b0;
        sv_model[slot]   = 1'b1;
        chk("ld_done_pulse", 64'(bus.load_done_o), 64'd1);
        chk("ld_ready_drop", 64'(bus.load_ready_o), 64'd0);
        chk("ld_idle", 64'(bus.busy_o), 64'd0);
        chk("ld_slot_valid", 64'(bus.slot_valid_o), 64'(sv_model));
        @(negedge clk);
        chk("ld_done_one_cycle", 64'(bus.load_done_o), 64'd0);
    endtask

    task automatic store_mx(input int slot, input bit tr, input bit stall);
        int cyc   = 0;
        int beats = 0;
        int n     = m_rows[slot] * m_cols[slot];
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        if (!tr) begin
            for (int r = 0; r < m_rows[slot]; r++)
                for (int c = 0; c < m_cols[slot]; c++) exp_q.push_back(model[slot][r][c]);
        end else begin
            for (int c = 0; c < m_cols[slot]; c++)
                for (int r = 0; r < m_rows[slot]; r++) exp_q.push_back(model[slot][r][c]);
        end
        @(negedge clk);
        bus.store_req_i       = 1'b1;
        bus.store_slot_i      = SW'(slot);
        bus.store_transpose_i = tr;
        @(negedge clk);
        bus.store_req_i = 1'b0;
        while (exp_q.size() != 0 && cyc < 100) begin
            bus.store_ready_i = stall ? pat[cyc % 4] : 1'b1;
            chk("st_valid", 64'(bus.store_valid_o), 64'd1);
            chk("st_data", bus.store_data_o, exp_q[0]);
            chk("st_last", 64'(bus.store_last_o), 64'(exp_q.size() == 1));
            if (bus.store_ready_i) begin
                void'(exp_q.pop_front());
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.store_ready_i = 1'b0;
        if (cyc >= 100) begin
            chk("st_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        chk("st_beats", 64'(beats), 64'(n));
        chk("st_done_pulse", 64'(bus.store_done_o), 64'd1);
        chk("st_valid_drop", 64'(bus.store_valid_o), 64'd0);
        chk("st_idle", 64'(bus.busy_o), 64'd0);
        chk("st_slot_kept", 64'(bus.slot_valid_o), 64'(sv_model));
        @(negedge clk);
        chk("st_done_one_cycle", 64'(bus.store_done_o), 64'd0);
    endtask

    task automatic bad_req(input string tag, input bit is_load, input int slot, input int rows, input int cols);
        @(negedge clk);
        bus.load_req_i   = is_load;
        bus.store_req_i  = !is_load;
        bus.load_slot_i  = SW'(slot);
        bus.store_slot_i = SW'(slot);
        bus.load_rows_i  = RDW'(rows);
        bus.load_cols_i  = CDW'(cols);
        @(negedge clk);
        bus.load_req_i  = 1'b0;
        bus.store_req_i = 1'b0;
        chk({tag, "_error"}, 64'(bus.error_o), 64'd1);
        chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
        chk({tag, "_slots"}, 64'(bus.slot_valid_o), 64'(sv_model));
        @(negedge clk);
        chk({tag, "_error_clear"}, 64'(bus.error_o), 64'd0);
        chk({tag, "_still_idle"}, 64'(bus.busy_o), 64'd0);
    endtask

    initial begin
        rst                   = 1'b1;
        bus.load_req_i        = 1'b0;
        bus.load_slot_i       = '0;
        bus.load_rows_i       = '0;
        bus.load_cols_i       = '0;
        bus.load_data_i       = '0;
        bus.load_valid_i      = 1'b0;
        bus.store_req_i       = 1'b0;
        bus.store_slot_i      = '0;
        bus.store_transpose_i = 1'b0;
        bus.store_ready_i     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_ready", 64'(bus.load_ready_o), 64'd0);
        chk("rst_store_valid", 64'(bus.store_valid_o), 64'd0);
        chk("rst_slots", 64'(bus.slot_valid_o), 64'd0);
        chk("rst_error", 64'(bus.error_o), 64'd0);
        chk("rst_done", 64'({bus.load_done_o, bus.store_done_o, bus.store_last_o}), 64'd0);
        rst = 1'b0;

        // 2x3 matrix 1.0..6.0 into slot 0, then plain, transposed and stalled streams.
        load_mx(0, 2, 3, 1, 1'b0);
        store_mx(0, 1'b0, 1'b0);
        store_mx(0, 1'b1, 1'b0);
        store_mx(0, 1'b0, 1'b1);

        bad_req("bad_rows0", 1'b1, 0, 0, 3);
        bad_req("bad_cols5", 1'b1, 0, 2, MC + 1);
        bad_req("bad_store_slot1", 1'b0, 1, 1, 1);

        // Concurrent requests: 1x1 load wins, store to valid slot 0 dropped.
        load_mx(1, 1, 1, 9, 1'b1);
        store_mx(1, 1'b0, 1'b0);
        store_mx(0, 1'b1, 1'b1);

        // Reset in the middle of a 4x4 load into slot 1.
        @(negedge clk);
        bus.load_req_i  = 1'b1;
        bus.load_slot_i = SW'(1);
        bus.load_rows_i = RDW'(4);
        bus.load_cols_i = CDW'(4);
        @(negedge clk);
        bus.load_req_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.load_valid_i = 1'b1;
            bus.load_data_i  = $realtobits(real'(20 + k));
            @(negedge clk);
        end
        bus.load_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        sv_model = '0;
        chk("mid_rst_busy", 64'(bus.busy_o), 64'd0);
        chk("mid_rst_ready", 64'(bus.load_ready_o), 64'd0);
        chk("mid_rst_slots", 64'(bus.slot_valid_o), 64'd0);
        bad_req("post_rst_store1", 1'b0, 1, 1, 1);
        bad_req("post_rst_store0", 1'b0, 0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
